// File: rtl/serial_ins_receiver.sv
// Receiving end of the bit-serial instruction link: frame counter, fetch address,
// LSB-first deserializer and R-type field decode.
module serial_ins_receiver #(
    parameter int FRAME_LAST = 98,
    parameter int PROG_BYTES = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ins,
    output logic [31:0] address,
    output logic [6:0]  cnt,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic        is_rtype
);

    localparam logic [6:0]  CNT_LAST  = 7'(FRAME_LAST);
    localparam logic [31:0] ADDR_WRAP = 32'(PROG_BYTES);
    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;

    logic [31:0] sr;
    logic [31:0] sr_next;
    logic [31:0] addr_inc;
    logic        in_window;

    // Transmitter puts bit k on the line while cnt == k+1.
    assign in_window = (cnt >= 7'd1) && (cnt <= 7'd32);
    assign sr_next   = {ins, sr[31:1]};
    assign addr_inc  = address + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            sr          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            address     <= '0;
        end else begin
            cnt         <= (cnt == CNT_LAST) ? 7'd0 : cnt + 7'd1;
            instr_valid <= 1'b0;
            if (in_window)
                sr <= sr_next;
            if (cnt == 7'd32) begin
                instr       <= sr_next;
                instr_valid <= 1'b1;
            end
            // Address moves only at frame end so it is stable across the whole window.
            if (cnt == CNT_LAST)
                address <= (addr_inc >= ADDR_WRAP) ? 32'd0 : addr_inc;
        end
    end

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];
    assign is_rtype = (opcode == OP_RTYPE);

endmodule

// File: doc/serial_ins_receiver.md
# serial_ins_receiver

Receiving end of the bit-serial instruction link from program memory. Program memory drives one instruction bit per clock, LSB first, during bits 0..31 of a fixed 99-cycle frame. This block generates the fetch address, deserializes the 32 bits into an instruction register and decodes the R-type fields for the serial datapath. It runs lock-step with the transmitter's frame counter; both are reset by the same `reset`.

## Interface
Parameters:
- `FRAME_LAST`, 98: last frame counter value; frame length is FRAME_LAST+1 cycles; must be ≥ 33.
- `PROG_BYTES`, 48: program size in bytes; fetch address wraps to 0 at this bound.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `ins`  in  1  serial instruction bit from program memory.
- `address`  out  32  byte address of the instruction being fetched (multiple of 4).
- `cnt`  out  7  frame counter, 0..FRAME_LAST.
- `instr`  out  32  last fully received instruction.
- `instr_valid`  out  1  one-cycle pulse: `instr` and the field outputs were just updated.
- `opcode`  out  7  `instr[6:0]`.
- `rd`  out  5  `instr[11:7]`.
- `funct3`  out  3  `instr[14:12]`.
- `rs1`  out  5  `instr[19:15]`.
- `rs2`  out  5  `instr[24:20]`.
- `funct7`  out  7  `instr[31:25]`.
- `is_rtype`  out  1  high when `opcode == 7'b0110011`.

## Operation
- Frame counter `cnt`: increments by 1 every cycle; at `cnt == FRAME_LAST` it goes to 0 on the next edge. This matches the transmitter's `0..98` count.
- Transmitter alignment: the bit with index k is valid on `ins` while `cnt == k+1`, for k = 0..31.
- Capture window is `cnt` 1..32. On each of those edges the 32-bit shift register updates as `sr <= {ins, sr[31:1]}`. After 32 shifts, bit 0 sits in `sr[0]`.
- Commit: on the edge where `cnt == 32`, `instr <= {ins, sr[31:1]}` (the completed word) and `instr_valid <= 1`. On every other edge `instr_valid <= 0`.
- Outside the capture window, `ins` is ignored and `sr` holds its value.
- Field outputs are combinational slices of `instr`. They are stable for the whole frame between commits.
- Address sequencing: on the edge where `cnt == FRAME_LAST`, `address <= (address + 4 >= PROG_BYTES) ? 0 : address + 4`. `address` is therefore constant across the entire capture window of each frame.
- No state machine beyond the counter: states are effectively IDLE (`cnt` 0, 33..FRAME_LAST) and SHIFT (`cnt` 1..32).

## Timing
- Reset values (edge with `reset` high): `cnt` 0, `sr` 0, `instr` 0, `instr_valid` 0, `address` 0. Decoded fields are 0 and `is_rtype` is 0.
- `reset` overrides counting, shifting, commit and address update in the same cycle.
- Reset mid-frame (e.g. at `cnt` 20) discards the partial word, leaves `instr` at 0 and restarts the frame at `address` 0. No `instr_valid` pulse occurs for the aborted frame.
- Latency: the first `instr_valid` pulse is high in the cycle where `cnt == 33`, which is 33 edges after reset deasserts. Subsequent pulses follow every FRAME_LAST+1 cycles (99 cycles by default).
- `instr_valid` is exactly one cycle wide. It is never high in two consecutive cycles.
- Address wrap: with default parameters, `address` runs 0,4,…,44 and then returns to 0. It changes only on the `cnt` FRAME_LAST→0 transition.
- All outputs are registered or pure slices of registers. There is no combinational path from `ins` to any output.

## Test plan
- Reset, then serialize 0x00730333 LSB-first with transmitter timing. Required in the cycle where `cnt == 33`: `instr_valid` = 1, `instr` = 0x00730333, `opcode` 0x33, `rd` 6, `rs1` 6, `rs2` 7, `funct3` 0, `funct7` 0, `is_rtype` 1.
- Serialize 0x00000293. Required: `instr` = 0x00000293, `opcode` 0x13, `rd` 5, `is_rtype` 0.
- Free-run 13 frames. Required: `address` sequence 0,4,…,44,0, each value held for 99 cycles; `instr_valid` pulses at cycles 33, 132, 231, …
- Drive `ins` toggling during `cnt` 0 and 33..98, with a constant word in the window. Required: `instr` equals the windowed word only; the out-of-window toggling has no effect.
- Assert `reset` one cycle at `cnt` 20 of the frame at `address` 8. Required next cycle: `cnt` 0, `address` 0, `instr` 0; no pulse until 33 cycles later.
- Receive 0xFFFFFFFF, then 0x00000000. Required: `funct7` goes 0x7F then 0x00, and each value is held stable between pulses.
